// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage pipelined carry-lookahead adder with valid/ready flow control.
// Stage 1 captures bit and group propagate/generate terms; stage 2 resolves the carries
// and registers sum, carry-out and signed overflow. Any WIDTH, any GROUP size.
module cla_pipe_adder #(
  parameter int WIDTH = 28,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NG = (WIDTH + GROUP - 1) / GROUP;
  localparam int PW = NG * GROUP;

  // Group propagate: a carry passes through only if every bit propagates.
  function automatic logic grp_prop(input logic [GROUP-1:0] p);
    return &p;
  endfunction

  // Group generate: carry produced somewhere in the group and propagated to its top.
  function automatic logic grp_gen(input logic [GROUP-1:0] p, input logic [GROUP-1:0] g);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < GROUP; k++) begin
      acc = g[k] | (p[k] & acc);
    end
    return acc;
  endfunction

  logic             adv1;
  logic             adv2;
  logic             vld_p1;
  logic             vld_p2;

  logic [PW-1:0]    a_pad;
  logic [PW-1:0]    b_pad;
  logic [PW-1:0]    p_pad;
  logic [PW-1:0]    g_pad;
  logic [NG-1:0]    pg_c;
  logic [NG-1:0]    gg_c;

  logic [WIDTH-1:0] x_p1;
  logic [WIDTH-1:0] p_p1;
  logic [WIDTH-1:0] g_p1;
  logic [NG-1:0]    pg_p1;
  logic [NG-1:0]    gg_p1;
  logic             cin_p1;

  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;

  // Backpressure: a stage advances when it is empty or the stage after it advances.
  assign adv2      = !vld_p2 || out_ready;
  assign adv1      = !vld_p1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = vld_p2;

  // ---- stage 0 -> stage 1 boundary ----
  // Pad bits above WIDTH are zero, so they contribute p=0, g=0 to the top group.
  assign a_pad = PW'(in_a);
  assign b_pad = PW'(in_b);
  assign p_pad = a_pad | b_pad;
  assign g_pad = a_pad & b_pad;

  // Per-group propagate/generate terms from the padded bit terms.
  always_comb begin
    pg_c = '0;
    gg_c = '0;
    for (int j = 0; j < NG; j++) begin
      pg_c[j] = grp_prop(p_pad[j*GROUP +: GROUP]);
      gg_c[j] = grp_gen(p_pad[j*GROUP +: GROUP], g_pad[j*GROUP +: GROUP]);
    end
  end

  // Pipeline valid bits; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv1) vld_p1 <= in_valid;
      if (adv2) vld_p2 <= vld_p1;
    end
  end

  // Stage 1 data capture on accept; holds while the pipe is stalled.
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      x_p1   <= in_a ^ in_b;
      p_p1   <= p_pad[WIDTH-1:0];
      g_p1   <= g_pad[WIDTH-1:0];
      pg_p1  <= pg_c;
      gg_p1  <= gg_c;
      cin_p1 <= in_cin;
    end
  end

  // ---- stage 1 -> stage 2 boundary ----
  // Lookahead over groups gives each group's carry-in; ripple inside the group
  // fills the bit carries. cout/ovf use the carry at bit WIDTH, never the pad edge.
  always_comb begin
    logic [NG:0]    cg;
    logic [WIDTH:0] cc;
    cg    = '0;
    cc    = '0;
    cg[0] = cin_p1;
    for (int j = 0; j < NG; j++) begin
      cg[j+1] = gg_p1[j] | (pg_p1[j] & cg[j]);
    end
    cc[0] = cin_p1;
    for (int i = 1; i <= WIDTH; i++) begin
      if (i % GROUP == 0) cc[i] = cg[i/GROUP];
      else                cc[i] = g_p1[i-1] | (p_p1[i-1] & cc[i-1]);
    end
    sum_c  = x_p1 ^ cc[WIDTH-1:0];
    cout_c = cc[WIDTH];
    ovf_c  = cc[WIDTH-1] ^ cc[WIDTH];
  end

  // Result register: loads only real beats, holds stable under stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (adv2 && vld_p1) begin
      out_sum  <= sum_c;
      out_cout <= cout_c;
      out_ovf  <= ovf_c;
    end
  end

endmodule
